// File: rtl/cmm_errman_pkg.sv
// cmm_errman_pkg: shared message-class encodings and scheduler state type
package cmm_errman_pkg;
  localparam logic [1:0] MSG_COR = 2'b00;
  localparam logic [1:0] MSG_NFL = 2'b01;
  localparam logic [1:0] MSG_FTL = 2'b11;
  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/cmm_errman_pend_cnt.sv
// cmm_errman_pend_cnt: saturating pending-error counter with sticky overflow flag
module cmm_errman_pend_cnt #(
  parameter int NSRC  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [NSRC-1:0]  err,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovfl
);
  localparam logic [CNT_W+1:0] MAX = {2'b00, {CNT_W{1'b1}}};
  logic [CNT_W+1:0] inc, nxt;
  logic sat;
  always_comb begin
    inc = en ? (CNT_W+2)'($countones(err)) : '0;
    nxt = {2'b00, cnt} + inc - {{(CNT_W+1){1'b0}}, dec};
    sat = nxt > MAX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      ovfl <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      ovfl <= 1'b0;
    end else begin
      cnt  <= sat ? MAX[CNT_W-1:0] : nxt[CNT_W-1:0];
      ovfl <= ovfl | sat;
    end
endmodule

// File: rtl/cmm_errman_msg_ctl.sv
// cmm_errman_msg_ctl: counts error pulses per class and sequences one error message at a time
module cmm_errman_msg_ctl
  import cmm_errman_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cor_en,
  input  logic             nfl_en,
  input  logic             ftl_en,
  input  logic [NSRC-1:0]  cor_err,
  input  logic [NSRC-1:0]  nfl_err,
  input  logic [NSRC-1:0]  ftl_err,
  input  logic             msg_ack,
  output logic             msg_req,
  output logic [1:0]       msg_type,
  output logic [CNT_W-1:0] cor_pend,
  output logic [CNT_W-1:0] nfl_pend,
  output logic [CNT_W-1:0] ftl_pend,
  output logic [2:0]       cnt_ovfl
);
  state_t state, state_nxt;
  logic [1:0] type_q, type_nxt;
  logic [2:0] dec;
  cmm_errman_pend_cnt #(.NSRC(NSRC), .CNT_W(CNT_W)) u_cor (
    .clk(clk), .rst(rst), .clr(!enable), .en(cor_en), .err(cor_err),
    .dec(dec[0]), .cnt(cor_pend), .ovfl(cnt_ovfl[0]));
  cmm_errman_pend_cnt #(.NSRC(NSRC), .CNT_W(CNT_W)) u_nfl (
    .clk(clk), .rst(rst), .clr(!enable), .en(nfl_en), .err(nfl_err),
    .dec(dec[1]), .cnt(nfl_pend), .ovfl(cnt_ovfl[1]));
  cmm_errman_pend_cnt #(.NSRC(NSRC), .CNT_W(CNT_W)) u_ftl (
    .clk(clk), .rst(rst), .clr(!enable), .en(ftl_en), .err(ftl_err),
    .dec(dec[2]), .cnt(ftl_pend), .ovfl(cnt_ovfl[2]));
  // type_q returns to MSG_COR (00) outside REQ, so it doubles as the msg_type output
  always_comb begin
    state_nxt = state;
    type_nxt  = type_q;
    dec       = '0;
    if (state == IDLE) begin
      state_nxt = (|{ftl_pend, nfl_pend, cor_pend}) ? REQ : IDLE;
      type_nxt  = (|ftl_pend) ? MSG_FTL : (|nfl_pend) ? MSG_NFL : MSG_COR;
    end else if (msg_ack) begin
      state_nxt = IDLE;
      type_nxt  = MSG_COR;
      dec       = {type_q == MSG_FTL, type_q == MSG_NFL, type_q == MSG_COR};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      type_q <= MSG_COR;
    end else if (!enable) begin
      state  <= IDLE;
      type_q <= MSG_COR;
    end else begin
      state  <= state_nxt;
      type_q <= type_nxt;
    end
  assign msg_req  = state == REQ;
  assign msg_type = type_q;
endmodule

// File: tb/tb_cmm_errman_msg_ctl.sv
// tb_cmm_errman_msg_ctl: scoreboard bench for the error-message scheduler
module tb_cmm_errman_msg_ctl;
  localparam logic [1:0] T_COR = 2'b00, T_NFL = 2'b01, T_FTL = 2'b11;
  logic clk = 0, rst = 1, enable = 1;
  logic cor_en = 1, nfl_en = 1, ftl_en = 1;
  logic [3:0] cor_err = 0, nfl_err = 0, ftl_err = 0;
  logic msg_ack = 0;
  logic msg_req;
  logic [1:0] msg_type;
  logic [3:0] cor_pend, nfl_pend, ftl_pend;
  logic [2:0] cnt_ovfl;
  int vectors = 0, miscompares = 0;
  logic [1:0] exp_q[$];
  cmm_errman_msg_ctl #(.NSRC(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cor_en(cor_en), .nfl_en(nfl_en),
    .ftl_en(ftl_en), .cor_err(cor_err), .nfl_err(nfl_err), .ftl_err(ftl_err),
    .msg_ack(msg_ack), .msg_req(msg_req), .msg_type(msg_type), .cor_pend(cor_pend),
    .nfl_pend(nfl_pend), .ftl_pend(ftl_pend), .cnt_ovfl(cnt_ovfl));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ack_next();
    int n = 0;
    while (!msg_req && n < 8) begin
      tick();
      n++;
    end
    chk("req_wait", msg_req, 1);
    msg_ack = 1;
    tick();
    msg_ack = 0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, msg_req, 0);
    chk({tag, "_type"}, msg_type, 0);
    chk({tag, "_pend"}, {cor_pend, nfl_pend, ftl_pend}, 0);
    chk({tag, "_ovfl"}, cnt_ovfl, 0);
  endtask
  always @(negedge clk)
    if (!rst && msg_req && msg_ack) begin
      chk("msg_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("msg_type", msg_type, exp_q.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 0;
    tick();
    // single NFL error with ack tied high
    msg_ack = 1;
    nfl_err = 4'b0001;
    exp_q.push_back(T_NFL);
    tick();
    nfl_err = 0;
    chk("s1_pend1", nfl_pend, 1);
    chk("s1_req_c1", msg_req, 0);
    tick();
    chk("s1_req_c2", msg_req, 1);
    chk("s1_type_c2", msg_type, T_NFL);
    tick();
    chk("s1_pend3", nfl_pend, 0);
    chk("s1_req_c3", msg_req, 0);
    msg_ack = 0;
    // FTL beats COR; request held three cycles before ack
    cor_err = 4'b0011;
    ftl_err = 4'b0001;
    exp_q.push_back(T_FTL);
    exp_q.push_back(T_COR);
    exp_q.push_back(T_COR);
    tick();
    cor_err = 0;
    ftl_err = 0;
    chk("s2_cor2", cor_pend, 2);
    chk("s2_ftl1", ftl_pend, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_hold_req", msg_req, 1);
      chk("s2_hold_type", msg_type, T_FTL);
    end
    msg_ack = 1;
    tick();
    msg_ack = 0;
    chk("s2_ftl0", ftl_pend, 0);
    chk("s2_gap_req", msg_req, 0);
    ack_next();
    chk("s2_cor1", cor_pend, 1);
    ack_next();
    chk("s2_cor0", cor_pend, 0);
    // saturation
    cor_err = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) cor_err = 0;
      chk("s3_pend", cor_pend, (4 * k > 15) ? 15 : 4 * k);
      chk("s3_ovfl", cnt_ovfl[0], k >= 4);
    end
    repeat (15) exp_q.push_back(T_COR);
    repeat (15) ack_next();
    chk("s3_drained", cor_pend, 0);
    chk("s3_sticky", cnt_ovfl[0], 1);
    enable = 0;
    tick();
    enable = 1;
    chk("s3_ovfl_clr", cnt_ovfl, 0);
    // increment and decrement in the same cycle
    nfl_err = 4'b0011;
    tick();
    nfl_err = 4'b0001;
    chk("s4_pend2", nfl_pend, 2);
    tick();
    chk("s4_pend3", nfl_pend, 3);
    chk("s4_type", msg_type, T_NFL);
    nfl_err = 4'b0011;
    msg_ack = 1;
    exp_q.push_back(T_NFL);
    tick();
    nfl_err = 0;
    msg_ack = 0;
    chk("s4_net", nfl_pend, 4);
    repeat (4) exp_q.push_back(T_NFL);
    repeat (4) ack_next();
    chk("s4_drained", nfl_pend, 0);
    // masked FTL, no retraction of a COR request
    ftl_en = 0;
    ftl_err = 4'b1111;
    cor_err = 4'b0001;
    exp_q.push_back(T_COR);
    tick();
    cor_err = 0;
    chk("s5_ftl_mask", ftl_pend, 0);
    chk("s5_cor1", cor_pend, 1);
    tick();
    ftl_err = 0;
    chk("s5_req", msg_req, 1);
    chk("s5_type", msg_type, T_COR);
    cor_en = 0;
    nfl_err = 4'b0001;
    exp_q.push_back(T_NFL);
    tick();
    nfl_err = 0;
    chk("s5_nfl1", nfl_pend, 1);
    for (int i = 0; i < 2; i++) begin
      chk("s5_hold_req", msg_req, 1);
      chk("s5_hold_type", msg_type, T_COR);
      if (i == 0) tick();
    end
    msg_ack = 1;
    tick();
    msg_ack = 0;
    cor_en = 1;
    ftl_en = 1;
    chk("s5_cor0", cor_pend, 0);
    ack_next();
    chk("s5_nfl0", nfl_pend, 0);
    chk("s5_ftl0", ftl_pend, 0);
    // enable dropped mid-request
    {cor_err, nfl_err, ftl_err} = 12'hfff;
    tick();
    {cor_err, nfl_err, ftl_err} = 12'h111;
    tick();
    {cor_err, nfl_err, ftl_err} = 0;
    chk("s6_pend5", {cor_pend, nfl_pend, ftl_pend}, 12'h555);
    chk("s6_req", msg_req, 1);
    chk("s6_type", msg_type, T_FTL);
    enable = 0;
    tick();
    enable = 1;
    chk_idle("s6_en");
    // asynchronous reset mid-request
    cor_err = 4'b0011;
    tick();
    cor_err = 0;
    tick();
    chk("s6_rst_req_before", msg_req, 1);
    #2 rst = 1;
    #1 chk_idle("s6_rst");
    #1 rst = 0;
    tick();
    chk_idle("s6_after_rst");
    chk("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
